// File: rtl/vga_frame_engine.sv
`default_nettype none
// ============================================================================
// Module   : vga_frame_engine
// Brief    : Parametrised VGA timing generator with latency-matched external
//            pixel path and built-in patterns (bars / LED columns / black).
// Revision : 1.0 - initial release
// ============================================================================
module vga_frame_engine #(
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter bit HS_POL  = 1'b0,
    parameter bit VS_POL  = 1'b0,
    parameter int PIX_LAT = 1
) (
    input  logic        vga_clk,
    input  logic        vga_rst,
    input  logic [1:0]  mode,
    input  logic [15:0] led,
    input  logic [11:0] pixel_data,
    output logic [10:0] pixel_xpos,
    output logic [10:0] pixel_ypos,
    output logic        frame_start,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [11:0] vga_rgb
);
    localparam logic [11:0] c_H_TOTAL  = 12'(H_DISP + H_FP + H_SYNC + H_BP);
    localparam logic [11:0] c_V_TOTAL  = 12'(V_DISP + V_FP + V_SYNC + V_BP);
    localparam logic [11:0] c_H_DISP   = 12'(H_DISP);
    localparam logic [11:0] c_V_DISP   = 12'(V_DISP);
    localparam logic [11:0] c_HS_START = 12'(H_DISP + H_FP);
    localparam logic [11:0] c_HS_END   = 12'(H_DISP + H_FP + H_SYNC);
    localparam logic [11:0] c_VS_START = 12'(V_DISP + V_FP);
    localparam logic [11:0] c_VS_END   = 12'(V_DISP + V_FP + V_SYNC);
    localparam logic [11:0] c_BAR_LAST = 12'(H_DISP / 8 - 1);
    localparam logic [11:0] c_COL_LAST = 12'(H_DISP / 16 - 1);

    logic [11:0] r_h_cnt, r_v_cnt;
    logic [11:0] r_bar_px, r_col_px;
    logic [2:0]  r_bar_idx;
    logic [3:0]  r_col_idx;
    logic [1:0]  r_mode_q;
    logic [15:0] r_led_q;

    logic        w_h_wrap, w_v_wrap, w_active, w_hs_raw, w_vs_raw;
    logic [1:0]  w_mode;
    logic [15:0] w_led;
    logic [11:0] w_pat;
    logic [15:0] w_stage0, w_dly_out;
    logic        w_d_active, w_d_hs, w_d_vs, w_d_ext;
    logic [11:0] w_d_pat;

    assign w_h_wrap = (r_h_cnt == c_H_TOTAL - 12'd1);
    assign w_v_wrap = (r_v_cnt == c_V_TOTAL - 12'd1);

    // Bar/column sub-counters track h_cnt so no divide is needed per pixel.
    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            r_h_cnt   <= 12'd0;
            r_v_cnt   <= 12'd0;
            r_bar_px  <= 12'd0;
            r_col_px  <= 12'd0;
            r_bar_idx <= 3'd0;
            r_col_idx <= 4'd0;
        end else if (w_h_wrap) begin
            r_h_cnt   <= 12'd0;
            r_v_cnt   <= w_v_wrap ? 12'd0 : r_v_cnt + 12'd1;
            r_bar_px  <= 12'd0;
            r_col_px  <= 12'd0;
            r_bar_idx <= 3'd0;
            r_col_idx <= 4'd0;
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
            if (r_bar_px == c_BAR_LAST) begin
                r_bar_px  <= 12'd0;
                r_bar_idx <= r_bar_idx + 3'd1;
            end else begin
                r_bar_px  <= r_bar_px + 12'd1;
            end
            if (r_col_px == c_COL_LAST) begin
                r_col_px  <= 12'd0;
                r_col_idx <= r_col_idx + 4'd1;
            end else begin
                r_col_px  <= r_col_px + 12'd1;
            end
        end
    end

    assign w_active    = (r_h_cnt < c_H_DISP) && (r_v_cnt < c_V_DISP);
    assign w_hs_raw    = (r_h_cnt >= c_HS_START) && (r_h_cnt < c_HS_END);
    assign w_vs_raw    = (r_v_cnt >= c_VS_START) && (r_v_cnt < c_VS_END);
    assign pixel_xpos  = w_active ? r_h_cnt[10:0] : 11'd0;
    assign pixel_ypos  = w_active ? r_v_cnt[10:0] : 11'd0;
    assign frame_start = (r_h_cnt == 12'd0) && (r_v_cnt == 12'd0) && !vga_rst;

    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            r_mode_q <= 2'd0;
            r_led_q  <= 16'd0;
        end else if (frame_start) begin
            r_mode_q <= mode;
            r_led_q  <= led;
        end
    end

    // Pixel (0,0) must already use the value being latched on that cycle.
    assign w_mode = frame_start ? mode : r_mode_q;
    assign w_led  = frame_start ? led  : r_led_q;

    always_comb begin
        w_pat = 12'h000;
        case (w_mode)
            2'd1: begin
                case (r_bar_idx)
                    3'd0:    w_pat = 12'hFFF;
                    3'd1:    w_pat = 12'hFF0;
                    3'd2:    w_pat = 12'h0FF;
                    3'd3:    w_pat = 12'h0F0;
                    3'd4:    w_pat = 12'hF0F;
                    3'd5:    w_pat = 12'hF00;
                    3'd6:    w_pat = 12'h00F;
                    default: w_pat = 12'h000;
                endcase
            end
            2'd2:    w_pat = w_led[4'd15 - r_col_idx] ? 12'h0F0 : 12'h222;
            default: w_pat = 12'h000;
        endcase
    end

    assign w_stage0 = {w_active, w_hs_raw, w_vs_raw, (w_mode == 2'd0), w_pat};

    generate
        if (PIX_LAT == 0) begin : g_no_dly
            assign w_dly_out = w_stage0;
        end else begin : g_dly
            logic [15:0] r_dly [PIX_LAT];
            always_ff @(posedge vga_clk) begin
                if (vga_rst) begin
                    for (int i = 0; i < PIX_LAT; i++) r_dly[i] <= 16'd0;
                end else begin
                    r_dly[0] <= w_stage0;
                    for (int i = 1; i < PIX_LAT; i++) r_dly[i] <= r_dly[i-1];
                end
            end
            assign w_dly_out = r_dly[PIX_LAT-1];
        end
    endgenerate

    assign {w_d_active, w_d_hs, w_d_vs, w_d_ext, w_d_pat} = w_dly_out;

    always_ff @(posedge vga_clk) begin
        if (vga_rst) begin
            vga_hs  <= ~HS_POL;
            vga_vs  <= ~VS_POL;
            vga_de  <= 1'b0;
            vga_rgb <= 12'h000;
        end else begin
            vga_hs  <= w_d_hs ? HS_POL : ~HS_POL;
            vga_vs  <= w_d_vs ? VS_POL : ~VS_POL;
            vga_de  <= w_d_active;
            vga_rgb <= !w_d_active ? 12'h000 : (w_d_ext ? pixel_data : w_d_pat);
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_vga_frame_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_frame_engine
// Brief    : Directed self-checking bench for vga_frame_engine (24x8 timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_vga_frame_engine;
    localparam int H_TOTAL = 24;
    localparam int F_TOTAL = 192;
    localparam int LAT     = 3;

    logic        clk = 1'b0;
    logic        vga_rst = 1'b1;
    logic [1:0]  mode = 2'd3;
    logic [15:0] led = 16'h0000;
    logic [11:0] pixel_data;
    logic [10:0] pixel_xpos, pixel_ypos;
    logic        frame_start, vga_hs, vga_vs, vga_de;
    logic [11:0] vga_rgb;
    logic [11:0] pd1 = 12'h000, pd2 = 12'h000;
    int          n_cmp = 0, n_bad = 0;

    vga_frame_engine #(
        .H_DISP(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_DISP(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .PIX_LAT(2)
    ) dut (
        .vga_clk(clk), .vga_rst(vga_rst), .mode(mode), .led(led),
        .pixel_data(pixel_data), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .frame_start(frame_start), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_de(vga_de), .vga_rgb(vga_rgb)
    );

    always #5 clk = ~clk;

    // External pixel source with two cycles of latency.
    always @(posedge clk) begin
        pd1 <= {1'b0, pixel_xpos[3:0], 7'b0};
        pd2 <= pd1;
    end
    assign pixel_data = pd2;

    function automatic logic [11:0] bar_colour(input int i);
        case (i)
            0: return 12'hFFF;
            1: return 12'hFF0;
            2: return 12'h0FF;
            3: return 12'h0F0;
            4: return 12'hF0F;
            5: return 12'hF00;
            6: return 12'h00F;
            default: return 12'h000;
        endcase
    endfunction

    // {hs, vs, de, rgb} expected for counter position p.
    function automatic logic [14:0] exp_vid(input int p, input logic [1:0] m, input logic [15:0] l);
        int q, h, v;
        logic de;
        logic [11:0] rgb;
        q = ((p % F_TOTAL) + F_TOTAL) % F_TOTAL;
        h = q % H_TOTAL;
        v = q / H_TOTAL;
        de = (h < 16) && (v < 4);
        rgb = 12'h000;
        if (de) begin
            case (m)
                2'd0: rgb = {1'b0, 4'(h), 7'b0};
                2'd1: rgb = bar_colour(h / 2);
                2'd2: rgb = l[15 - h] ? 12'h0F0 : 12'h222;
                default: rgb = 12'h000;
            endcase
        end
        return {!(h >= 18 && h <= 20), !(v == 5 || v == 6), de, rgb};
    endfunction

    // {frame_start, xpos, ypos} expected for counter position p.
    function automatic logic [22:0] exp_pos(input int p);
        int q, h, v;
        logic act;
        q = p % F_TOTAL;
        h = q % H_TOTAL;
        v = q / H_TOTAL;
        act = (h < 16) && (v < 4);
        return {(q == 0), act ? 11'(h) : 11'd0, act ? 11'(v) : 11'd0};
    endfunction

    task automatic release_reset();
        @(negedge clk);
        vga_rst = 1'b1;
        repeat (2) @(negedge clk);
        vga_rst = 1'b0;
    endtask

    task automatic test_reset();
        vga_rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({vga_hs, vga_vs, vga_de, vga_rgb} !== 15'h6000) begin
            n_bad++;
            $display("FAIL reset_outputs got %h want %h", {vga_hs, vga_vs, vga_de, vga_rgb}, 15'h6000);
        end
        n_cmp++;
        if ({frame_start, pixel_xpos, pixel_ypos} !== 23'd0) begin
            n_bad++;
            $display("FAIL reset_pos got %h want 0", {frame_start, pixel_xpos, pixel_ypos});
        end
    endtask

    task automatic test_timing();
        mode = 2'd3;
        release_reset();
        #1;
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_bad++;
            $display("FAIL timing_fs_release got %b want 1", frame_start);
        end
        for (int k = 1; k <= 2 * F_TOTAL + LAT; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({vga_hs, vga_vs, vga_de, vga_rgb} !== exp_vid(k - LAT, 2'd3, 16'h0)) begin
                n_bad++;
                $display("FAIL timing_video k=%0d got %h want %h", k, {vga_hs, vga_vs, vga_de, vga_rgb}, exp_vid(k - LAT, 2'd3, 16'h0));
            end
            n_cmp++;
            if ({frame_start, pixel_xpos, pixel_ypos} !== exp_pos(k)) begin
                n_bad++;
                $display("FAIL timing_pos k=%0d got %h want %h", k, {frame_start, pixel_xpos, pixel_ypos}, exp_pos(k));
            end
        end
    endtask

    task automatic test_pattern(input logic [1:0] m, input logic [15:0] l);
        mode = m;
        led  = l;
        release_reset();
        for (int k = 1; k <= F_TOTAL + LAT; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({vga_hs, vga_vs, vga_de, vga_rgb} !== exp_vid(k - LAT, m, l)) begin
                n_bad++;
                $display("FAIL pattern_m%0d k=%0d got %h want %h", m, k, {vga_hs, vga_vs, vga_de, vga_rgb}, exp_vid(k - LAT, m, l));
            end
        end
    endtask

    task automatic test_led_latch();
        logic [15:0] l_exp;
        mode = 2'd2;
        led  = 16'h8001;
        release_reset();
        for (int k = 1; k <= 2 * F_TOTAL + LAT; k++) begin
            @(negedge clk);
            l_exp = (k - LAT < F_TOTAL) ? 16'h8001 : 16'h00F0;
            n_cmp++;
            if ({vga_hs, vga_vs, vga_de, vga_rgb} !== exp_vid(k - LAT, 2'd2, l_exp)) begin
                n_bad++;
                $display("FAIL led_latch k=%0d got %h want %h", k, {vga_hs, vga_vs, vga_de, vga_rgb}, exp_vid(k - LAT, 2'd2, l_exp));
            end
            if (k == 30) led = 16'h00F0;
        end
    endtask

    task automatic test_frame_latch();
        logic [1:0] m_exp;
        mode = 2'd1;
        led  = 16'h8001;
        release_reset();
        for (int k = 1; k <= 2 * F_TOTAL + LAT; k++) begin
            @(negedge clk);
            m_exp = (k - LAT < F_TOTAL) ? 2'd1 : 2'd2;
            n_cmp++;
            if ({vga_hs, vga_vs, vga_de, vga_rgb} !== exp_vid(k - LAT, m_exp, 16'h8001)) begin
                n_bad++;
                $display("FAIL frame_latch k=%0d got %h want %h", k, {vga_hs, vga_vs, vga_de, vga_rgb}, exp_vid(k - LAT, m_exp, 16'h8001));
            end
            if (k == 50) mode = 2'd2;
        end
    endtask

    task automatic test_mid_reset();
        mode = 2'd1;
        release_reset();
        for (int k = 1; k <= 82; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({vga_hs, vga_vs, vga_de, vga_rgb} !== exp_vid(k - LAT, 2'd1, 16'h0)) begin
                n_bad++;
                $display("FAIL mid_reset_pre k=%0d got %h want %h", k, {vga_hs, vga_vs, vga_de, vga_rgb}, exp_vid(k - LAT, 2'd1, 16'h0));
            end
        end
        // Position (10,3) is current; reset for exactly one edge.
        vga_rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({vga_hs, vga_vs, vga_de, vga_rgb} !== 15'h6000) begin
            n_bad++;
            $display("FAIL mid_reset_inactive got %h want %h", {vga_hs, vga_vs, vga_de, vga_rgb}, 15'h6000);
        end
        vga_rst = 1'b0;
        #1;
        n_cmp++;
        if (frame_start !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_reset_fs got %b want 1", frame_start);
        end
        for (int k = 1; k <= F_TOTAL + LAT; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({vga_hs, vga_vs, vga_de, vga_rgb} !== exp_vid(k - LAT, 2'd1, 16'h0)) begin
                n_bad++;
                $display("FAIL mid_reset_video k=%0d got %h want %h", k, {vga_hs, vga_vs, vga_de, vga_rgb}, exp_vid(k - LAT, 2'd1, 16'h0));
            end
            n_cmp++;
            if ({frame_start, pixel_xpos, pixel_ypos} !== exp_pos(k)) begin
                n_bad++;
                $display("FAIL mid_reset_pos k=%0d got %h want %h", k, {frame_start, pixel_xpos, pixel_ypos}, exp_pos(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_timing();
        test_pattern(2'd0, 16'h0000);
        test_pattern(2'd1, 16'h0000);
        test_pattern(2'd2, 16'h8001);
        test_led_latch();
        test_frame_latch();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
